// File: rtl/simple_mem.sv
// simple_mem: dual-port (instruction read, data read/write) word memory with an optional clear-on-reset sweep
module simple_mem #(
  parameter int          DEPTH_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        ready_o,
  input  logic        i_read_i,
  input  logic [31:0] i_raddr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_read_i,
  input  logic        d_write_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o
);
  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT  = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   i_off, d_off;
  logic          i_in, d_in, d_we;
  logic [AW-1:0] i_idx, d_idx;
  assign i_off   = i_raddr_i - BASE_ADDR;
  assign d_off   = d_addr_i - BASE_ADDR;
  assign i_in    = {1'b0, i_off} < LIMIT;
  assign d_in    = {1'b0, d_off} < LIMIT;
  assign i_idx   = i_off[AW+1:2];
  assign d_idx   = d_off[AW+1:2];
  assign ready_o = state == S_READY;
  assign d_we    = ready_o && d_write_i && d_in;
  // controller: RESET -> (CLEAR sweep) -> READY
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= S_RESET;
      clr_cnt <= '0;
    end else if (state == S_RESET) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH_WORDS - 1)) state <= S_READY;
    end
  end
  // storage: one zero word per cycle while clearing, byte-masked data writes when ready
  always_ff @(posedge clk_i) begin
    if (state == S_CLEAR) mem[clr_cnt] <= '0;
    else if (d_we)
      for (int b = 0; b < 4; b++)
        if (d_be_i[b]) mem[d_idx][8*b +: 8] <= d_wdata_i[8*b +: 8];
  end
  // registered read ports; reads sample the pre-write word, outputs hold when idle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      i_rdata_o <= '0;
      i_err_o   <= 1'b0;
      d_rdata_o <= '0;
      d_err_o   <= 1'b0;
    end else if (ready_o) begin
      if (i_read_i) begin
        i_rdata_o <= i_in ? mem[i_idx] : '0;
        i_err_o   <= !i_in;
      end
      if (d_read_i || d_write_i) d_err_o <= !d_in;
      if (d_read_i) d_rdata_o <= d_in ? mem[d_idx] : '0;
    end
  end
endmodule

// File: tb/tb_simple_mem.sv
// tb_simple_mem: directed checks of simple_mem (default build and a 16-word clear-on-reset build)
module tb_simple_mem;
  logic        clk_i = 1'b0;
  logic        rstn0, ready0, i_read0, i_err0, d_read0, d_write0, d_err0;
  logic [31:0] i_raddr0, i_rdata0, d_addr0, d_wdata0, d_rdata0;
  logic [3:0]  d_be0;
  logic        rstn1, ready1, i_read1, i_err1, d_read1, d_write1, d_err1;
  logic [31:0] i_raddr1, i_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic [3:0]  d_be1;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n;
  always #5 clk_i = ~clk_i;
  simple_mem dut0 (
    .clk_i(clk_i), .rstn_i(rstn0), .ready_o(ready0),
    .i_read_i(i_read0), .i_raddr_i(i_raddr0), .i_rdata_o(i_rdata0), .i_err_o(i_err0),
    .d_read_i(d_read0), .d_write_i(d_write0), .d_addr_i(d_addr0), .d_be_i(d_be0),
    .d_wdata_i(d_wdata0), .d_rdata_o(d_rdata0), .d_err_o(d_err0)
  );
  simple_mem #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk_i(clk_i), .rstn_i(rstn1), .ready_o(ready1),
    .i_read_i(i_read1), .i_raddr_i(i_raddr1), .i_rdata_o(i_rdata1), .i_err_o(i_err1),
    .d_read_i(d_read1), .d_write_i(d_write1), .d_addr_i(d_addr1), .d_be_i(d_be1),
    .d_wdata_i(d_wdata1), .d_rdata_o(d_rdata1), .d_err_o(d_err1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    d_write0 = 1'b1; d_addr0 = a; d_wdata0 = d; d_be0 = be;
    step();
    d_write0 = 1'b0;
  endtask
  task automatic rd0(input logic [31:0] a);
    d_read0 = 1'b1; d_addr0 = a;
    step();
    d_read0 = 1'b0;
  endtask
  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    d_write1 = 1'b1; d_addr1 = a; d_wdata1 = d; d_be1 = 4'hF;
    step();
    d_write1 = 1'b0;
  endtask
  task automatic rd1(input logic [31:0] a);
    d_read1 = 1'b1; d_addr1 = a;
    step();
    d_read1 = 1'b0;
  endtask
  task automatic wait_ready1(output int cycles);
    cycles = 0;
    while (!ready1 && cycles < 40) begin
      step();
      cycles++;
    end
  endtask
  initial begin
    rstn0 = 1'b0; i_read0 = 0; i_raddr0 = 0; d_read0 = 0; d_write0 = 0; d_addr0 = 0; d_be0 = 0; d_wdata0 = 0;
    rstn1 = 1'b0; i_read1 = 0; i_raddr1 = 0; d_read1 = 0; d_write1 = 0; d_addr1 = 0; d_be1 = 0; d_wdata1 = 0;
    step();
    step();
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_i_rdata", i_rdata0, 32'd0);
    chk("rst_d_rdata", d_rdata0, 32'd0);
    chk("rst_errs", {30'd0, i_err0, d_err0}, 32'd0);
    rstn0 = 1'b1;
    step();
    chk("ready_after_rst", {31'd0, ready0}, 32'd1);
    wr0(32'h8000_0000, 32'h0000_0013, 4'hF);
    wr0(32'h8000_0004, 32'h0010_0093, 4'hF);
    wr0(32'h8000_0008, 32'hAABB_CCDD, 4'hF);
    wr0(32'h8000_000C, 32'h1234_5678, 4'hF);
    i_read0 = 1'b1; i_raddr0 = 32'h8000_0000;
    step();
    chk("iread_w0", i_rdata0, 32'h0000_0013);
    chk("iread_w0_err", {31'd0, i_err0}, 32'd0);
    i_raddr0 = 32'h8000_0004;
    step();
    chk("iread_w1", i_rdata0, 32'h0010_0093);
    i_read0 = 1'b0; i_raddr0 = 32'h8000_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("i_hold", i_rdata0, 32'h0010_0093);
    end
    wr0(32'h8000_0008, 32'h1122_3344, 4'b0101);
    rd0(32'h8000_0008);
    chk("be_merge", d_rdata0, 32'hAA22_CC44);
    chk("be_merge_err", {31'd0, d_err0}, 32'd0);
    wr0(32'h8000_0008, 32'h0000_0000, 4'b0000);
    rd0(32'h8000_0008);
    chk("be_zero_noop", d_rdata0, 32'hAA22_CC44);
    d_write0 = 1'b1; d_addr0 = 32'h8000_000C; d_wdata0 = 32'hFFFF_FFFF; d_be0 = 4'hF;
    i_read0 = 1'b1; i_raddr0 = 32'h8000_000C;
    step();
    d_write0 = 1'b0;
    chk("i_vs_dwrite_old", i_rdata0, 32'h1234_5678);
    step();
    i_read0 = 1'b0;
    chk("i_vs_dwrite_new", i_rdata0, 32'hFFFF_FFFF);
    d_read0 = 1'b1; d_write0 = 1'b1; d_addr0 = 32'h8000_0004; d_wdata0 = 32'hCAFE_BABE; d_be0 = 4'hF;
    step();
    d_write0 = 1'b0;
    chk("read_first_old", d_rdata0, 32'h0010_0093);
    step();
    d_read0 = 1'b0;
    chk("read_first_new", d_rdata0, 32'hCAFE_BABE);
    i_read0 = 1'b1; i_raddr0 = 32'h8000_4000;
    d_read0 = 1'b1; d_addr0 = 32'h7FFF_FFFC;
    step();
    i_read0 = 1'b0; d_read0 = 1'b0;
    chk("oor_i_rdata", i_rdata0, 32'd0);
    chk("oor_i_err", {31'd0, i_err0}, 32'd1);
    chk("oor_d_rdata", d_rdata0, 32'd0);
    chk("oor_d_err", {31'd0, d_err0}, 32'd1);
    rd0(32'h8000_0000);
    chk("rd_w0", d_rdata0, 32'h0000_0013);
    chk("rd_w0_err", {31'd0, d_err0}, 32'd0);
    wr0(32'h8000_4000, 32'h5555_5555, 4'hF);
    chk("oor_wr_err", {31'd0, d_err0}, 32'd1);
    chk("oor_wr_hold", d_rdata0, 32'h0000_0013);
    rd0(32'h8000_0000);
    chk("oor_wr_nochange", d_rdata0, 32'h0000_0013);
    wr0(32'h8000_3FFC, 32'h0BAD_F00D, 4'hF);
    rd0(32'h8000_3FFF);
    chk("last_word", d_rdata0, 32'h0BAD_F00D);
    chk("last_word_err", {31'd0, d_err0}, 32'd0);
    rstn1 = 1'b1;
    wait_ready1(n);
    chk("clear_cycles", n, 32'd17);
    wr1(32'h8000_0014, 32'hDEAD_BEEF);
    rd1(32'h8000_0014);
    chk("w5_written", d_rdata1, 32'hDEAD_BEEF);
    rstn1 = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, ready1}, 32'd0);
    chk("async_rst_rdata", d_rdata1, 32'd0);
    step();
    rstn1 = 1'b1;
    wait_ready1(n);
    chk("clear_cycles2", n, 32'd17);
    rd1(32'h8000_0014);
    chk("w5_cleared", d_rdata1, 32'd0);
    wr1(32'h8000_0014, 32'hDEAD_BEEF);
    rstn1 = 1'b0;
    step();
    rstn1 = 1'b1;
    d_read1 = 1'b1; d_addr1 = 32'h8000_0040;
    i_read1 = 1'b1; i_raddr1 = 32'h8000_0040;
    repeat (9) step();
    d_read1 = 1'b0; i_read1 = 1'b0;
    chk("clear_ignores_req", {30'd0, i_err1, d_err1}, 32'd0);
    chk("clear_ready_low", {31'd0, ready1}, 32'd0);
    rstn1 = 1'b0;
    step();
    rstn1 = 1'b1;
    wait_ready1(n);
    chk("restart_cycles", n, 32'd17);
    rd1(32'h8000_0014);
    chk("w5_after_restart", d_rdata1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
